simplez_mem_arbiter: RTL and testbench

//   Shares the single-port synchronous program/data RAM of the Simplez CPU between two

---
 rtl/simplez_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_simplez_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simplez_mem_arbiter.sv
// Round-robin arbiter sharing the Simplez single-port synchronous RAM between the
// CPU core (cpu_*) and the serial program loader (ldr_*), one access in flight.
module simplez_mem_arbiter #(
  parameter int AW        = 9,
  parameter int DW        = 12,
  parameter bit CPU_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  // Handshake (both ports): req rises and stays high until the one-cycle ack pulse;
  // we/addr/wdata are sampled only at grant; rdata is valid only while ack = 1.
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  input  logic          ldr_lock,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_READ   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t        state_q;
  logic          gnt_ldr_q;
  logic          rr_ldr_q;
  logic          we_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_din_q;
  logic          ram_we_q;
  logic          cpu_ack_q;
  logic          ldr_ack_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] ldr_rdata_q;
  logic          cpu_stall_q;

  logic cpu_acked;
  logic ldr_acked;
  logic cpu_elig;
  logic ldr_elig;
  logic arb_valid;
  logic arb_ldr;

  // A port acked in RESP still holds its old req, so it must sit out this arbitration.
  always_comb begin
    cpu_acked = (state_q == S_RESP) && !gnt_ldr_q;
    ldr_acked = (state_q == S_RESP) && gnt_ldr_q;
    cpu_elig  = cpu_req && !cpu_acked && !ldr_lock;
    ldr_elig  = ldr_req && !ldr_acked;
    arb_valid = cpu_elig || ldr_elig;
    arb_ldr   = ldr_elig && (!cpu_elig || !rr_ldr_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      gnt_ldr_q   <= 1'b0;
      rr_ldr_q    <= CPU_FIRST;
      we_q        <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      cpu_stall_q <= 1'b0;
    end else begin
      cpu_stall_q <= ldr_lock;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      case (state_q)
        S_IDLE, S_RESP: begin
          if (arb_valid) begin
            state_q    <= S_ACCESS;
            gnt_ldr_q  <= arb_ldr;
            rr_ldr_q   <= arb_ldr;
            we_q       <= arb_ldr ? ldr_we    : cpu_we;
            ram_we_q   <= arb_ldr ? ldr_we    : cpu_we;
            ram_addr_q <= arb_ldr ? ldr_addr  : cpu_addr;
            ram_din_q  <= arb_ldr ? ldr_wdata : cpu_wdata;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ACCESS: state_q <= S_READ;
        S_READ: begin
          // Writes echo the written word so the result does not depend on RAM read-during-write mode.
          if (gnt_ldr_q) ldr_rdata_q <= we_q ? ram_din_q : ram_dout;
          else           cpu_rdata_q <= we_q ? ram_din_q : ram_dout;
          cpu_ack_q <= !gnt_ldr_q;
          ldr_ack_q <= gnt_ldr_q;
          state_q   <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign cpu_stall = cpu_stall_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// Directed bench for simplez_mem_arbiter with a behavioural single-port synchronous RAM.
module tb_simplez_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          ldr_req = 1'b0;
  logic          ldr_we = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic          ldr_ack;
  logic [DW-1:0] ldr_rdata;
  logic          ldr_lock = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout = '0;
  logic [1:0]    dbg_state;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt = 0;
  int cpu_ack_cnt = 0;
  int ldr_ack_cnt = 0;
  int dual_cnt = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  logic [DW-1:0] exp_q [$];
  logic [15:0]   ord_q [$];

  simplez_mem_arbiter #(.AW(AW), .DW(DW), .CPU_FIRST(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata), .ldr_lock(ldr_lock),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: write and registered read at the clock edge
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (cpu_ack) cpu_ack_cnt++;
    if (ldr_ack) ldr_ack_cnt++;
    if (cpu_ack && ldr_ack) dual_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // driver: raises req in a fresh cycle, waits for ack, checks latency and data; req stays high
  task automatic do_access(input bit ldr, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp, input string tag);
    int lat;
    @(posedge clk); #1;
    if (ldr) begin
      ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((ldr ? ldr_ack : cpu_ack) === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, 3);
    if (lat >= 0) check({tag, "_data"}, ldr ? ldr_rdata : cpu_rdata, exp);
    last_ack_cyc = cyc;
  endtask

  task automatic release_req(input bit ldr);
    @(posedge clk); #1;
    if (ldr) begin ldr_req = 1'b0; ldr_we = 1'b0; end
    else begin cpu_req = 1'b0; cpu_we = 1'b0; end
  endtask

  initial begin
    int snap;
    int prev;
    int gap;
    logic [15:0] ev;

    do_reset();
    @(negedge clk);
    check("rst_state", dbg_state, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_acks", {cpu_ack, ldr_ack, cpu_stall}, 0);
    check("rst_rdata", {cpu_rdata, ldr_rdata}, 0);

    // preload through the loader port
    do_access(1, 1, 9'h005, 12'h123, 12'h123, "pre5");
    do_access(1, 1, 9'h010, 12'h000, 12'h000, "pre10");
    for (int i = 0; i < 4; i++)
      do_access(1, 1, AW'(i), DW'(12'h111 * (i + 1)), DW'(12'h111 * (i + 1)), "pre_lo");
    release_req(1);

    // 1: CPU read
    snap = we_cnt;
    do_access(0, 0, 9'h005, 12'hFFF, 12'h123, "t1_read");
    release_req(0);
    check("t1_no_write", we_cnt - snap, 0);

    // 2: loader write then read
    snap = we_cnt;
    do_access(1, 1, 9'h0A0, 12'hABC, 12'hABC, "t2_write");
    release_req(1);
    check("t2_we_pulse", we_cnt - snap, 1);
    check("t2_mem", mem[9'h0A0], 12'hABC);
    do_access(1, 0, 9'h0A0, 12'h000, 12'hABC, "t2_read");
    release_req(1);

    // 3: both requesting continuously, CPU wins the first tie after reset
    do_reset();
    snap = dual_cnt;
    ord_q.push_back({4'h0, 12'd3});
    ord_q.push_back({4'h1, 12'd6});
    ord_q.push_back({4'h0, 12'd9});
    ord_q.push_back({4'h1, 12'd12});
    ord_q.push_back({4'h0, 12'd15});
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 9'h0A0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (cpu_ack || ldr_ack) begin
        ev = (ord_q.size() > 0) ? ord_q.pop_front() : 16'hFFFF;
        check("t3_order", {3'b000, ldr_ack, 12'(c)}, ev);
        if (cpu_ack) check("t3_cpu_data", cpu_rdata, 12'h123);
        if (ldr_ack) check("t3_ldr_data", ldr_rdata, 12'hABC);
      end
      if (c == 12) begin
        @(posedge clk); #1 ldr_req = 1'b0;
      end
    end
    release_req(0);
    check("t3_all_acks", ord_q.size(), 0);
    check("t3_no_dual", dual_cnt - snap, 0);

    // 4: loader lock starves the CPU
    repeat (2) @(posedge clk);
    #1;
    ldr_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    @(negedge clk);
    check("t4_stall_lag", cpu_stall, 0);
    @(negedge clk);
    check("t4_stall", cpu_stall, 1);
    snap = cpu_ack_cnt;
    do_access(1, 0, 9'h0A0, 12'h000, 12'hABC, "t4_ldr_a");
    do_access(1, 0, 9'h005, 12'h000, 12'h123, "t4_ldr_b");
    release_req(1);
    repeat (3) @(posedge clk);
    check("t4_cpu_blocked", cpu_ack_cnt - snap, 0);
    #1 ldr_lock = 1'b0;
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        prev = i;
        break;
      end
    end
    check("t4_unlock_lat", prev, 3);
    check("t4_unlock_data", cpu_rdata, 12'h123);
    release_req(0);
    @(negedge clk);
    check("t4_stall_off", cpu_stall, 0);

    // 5: reset during the ACCESS cycle of a CPU write
    snap = cpu_ack_cnt;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = 12'h055;
    @(posedge clk); #1;
    check("t5_access_state", dbg_state, 1);
    check("t5_access_we", ram_we, 1);
    #2 rstn = 1'b0;
    #1;
    check("t5_rst_we", ram_we, 0);
    check("t5_rst_state", dbg_state, 0);
    check("t5_rst_outs", {ram_addr, ram_din, cpu_ack, ldr_ack, cpu_stall}, 0);
    check("t5_rst_rdata", {cpu_rdata, ldr_rdata}, 0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    repeat (4) @(posedge clk);
    check("t5_mem_kept", mem[9'h010], 12'h000);
    check("t5_no_ack", cpu_ack_cnt - snap, 0);
    do_access(0, 0, 9'h010, 12'h000, 12'h000, "t5_fresh");
    release_req(0);

    // 6: CPU-only back-to-back reads
    snap = ldr_ack_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(DW'(12'h111 * (i + 1)));
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      do_access(0, 0, AW'(i), 12'h000, exp_q.pop_front(), "t6_read");
      if (prev >= 0) begin
        gap = last_ack_cyc - prev;
        check("t6_gap", (gap >= 3) && (gap <= 4), 1);
      end
      prev = last_ack_cyc;
    end
    release_req(0);
    repeat (3) @(posedge clk);
    check("t6_no_ldr_ack", ldr_ack_cnt - snap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
